// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-states and control-word bit positions.
// Imported by the control sequencer and its ring counter.
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   // Control word is laid out MSB-first as Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo.
   localparam int CW_WIDTH = 12;
   localparam int CW_CP    = 11;
   localparam int CW_EP    = 10;
   localparam int CW_LM    = 9;
   localparam int CW_CE    = 8;
   localparam int CW_LI    = 7;
   localparam int CW_EI    = 6;
   localparam int CW_LA    = 5;
   localparam int CW_EA    = 4;
   localparam int CW_SU    = 3;
   localparam int CW_EU    = 2;
   localparam int CW_LB    = 1;
   localparam int CW_LO    = 0;

   typedef logic [CW_WIDTH-1:0] ctrl_word_t;

   function automatic logic is_nop(input logic [3:0] op);
      return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
   endfunction

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// Bundle between the control sequencer and the SAP-1 datapath: opcode in, control word out.
// The sequencer takes the master side; the datapath model takes the slave side.
interface sap1_control_sequencer_if;
   logic [3:0] opCode;
   logic       Cp;
   logic       Ep;
   logic       Lm;
   logic       CE;
   logic       Li;
   logic       Ei;
   logic       La;
   logic       Ea;
   logic       Su;
   logic       Eu;
   logic       Lb;
   logic       Lo;
   logic       hlt;
   logic [5:0] tstate;

   modport master (
      input  opCode,
      output Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt, tstate
   );

   modport slave (
      output opCode,
      input  Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt, tstate
   );
endinterface

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-state ring, advancing on the falling clock edge.
// hold freezes the ring, early jumps back to T1; any non-one-hot value recovers to T1.
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic    clk,
   input  logic    clr,
   input  logic    hold,
   input  logic    early,
   output tstate_e tstate
);

   tstate_e state_q;
   tstate_e state_d;
   logic    legal;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      legal   = (state_q != 6'b0) && ((state_q & (state_q - 6'd1)) == 6'b0);
      if (!legal || early) begin
         state_d = T1;
      end else if (!hold) begin
         state_d = tstate_e'({state_q[4:0], state_q[5]});
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         state_q <= T1;
      end else begin
         state_q <= state_d;
      end
   end

   assign tstate = state_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state ring plus microcode decode into the 12-bit control word.
// Outputs are combinational from T-state, opcode, halt and clr; state moves on negedge.
module sap1_control_sequencer
   import sap1_pkg::*;
#(
   parameter bit SHORT_CYCLE = 1'b0
)(
   input  logic                     clk,
   input  logic                     clr,
   sap1_control_sequencer_if.master bus
);

   tstate_e    tstate;
   logic       hlt_q;
   logic       halt_now;
   logic       hold;
   logic       early;
   ctrl_word_t cw;

   sap1_ring_counter u_ring (
      .clk    (clk),
      .clr    (clr),
      .hold   (hold),
      .early  (early),
      .tstate (tstate)
   );

   // Halt is decided in T4 so NOPs in short-cycle mode still pass through the check.
   always_comb begin
      halt_now = !hlt_q && (tstate == T4) && (bus.opCode == OP_HLT);
      hold     = hlt_q || halt_now;
      early    = 1'b0;
      if (SHORT_CYCLE && !hold) begin
         case (tstate)
            T4:      early = (bus.opCode == OP_OUT) || is_nop(bus.opCode);
            T5:      early = (bus.opCode == OP_LDA);
            default: early = 1'b0;
         endcase
      end
   end

   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         hlt_q <= 1'b0;
      end else if (halt_now) begin
         hlt_q <= 1'b1;
      end
   end

   always_comb begin
      cw = '0;
      case (tstate)
         T1: begin
            cw[CW_EP] = 1'b1;
            cw[CW_LM] = 1'b1;
         end
         T2: cw[CW_CP] = 1'b1;
         T3: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LI] = 1'b1;
         end
         T4: begin
            case (bus.opCode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  cw[CW_EI] = 1'b1;
                  cw[CW_LM] = 1'b1;
               end
               OP_OUT: begin
                  cw[CW_EA] = 1'b1;
                  cw[CW_LO] = 1'b1;
               end
               default: cw = '0;
            endcase
         end
         T5: begin
            case (bus.opCode)
               OP_LDA: begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LA] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LB] = 1'b1;
               end
               default: cw = '0;
            endcase
         end
         T6: begin
            if (bus.opCode == OP_ADD || bus.opCode == OP_SUB) begin
               cw[CW_EU] = 1'b1;
               cw[CW_LA] = 1'b1;
               cw[CW_SU] = (bus.opCode == OP_SUB);
            end
         end
         default: cw = '0;
      endcase
      // clr and halt mask everything so no partial load lands on the next posedge.
      if (clr || hlt_q) begin
         cw = '0;
      end
   end

   assign bus.Cp     = cw[CW_CP];
   assign bus.Ep     = cw[CW_EP];
   assign bus.Lm     = cw[CW_LM];
   assign bus.CE     = cw[CW_CE];
   assign bus.Li     = cw[CW_LI];
   assign bus.Ei     = cw[CW_EI];
   assign bus.La     = cw[CW_LA];
   assign bus.Ea     = cw[CW_EA];
   assign bus.Su     = cw[CW_SU];
   assign bus.Eu     = cw[CW_EU];
   assign bus.Lb     = cw[CW_LB];
   assign bus.Lo     = cw[CW_LO];
   assign bus.hlt    = hlt_q;
   assign bus.tstate = tstate;

   a_single_driver : assert property (@(posedge clk) disable iff (clr)
      $onehot0({bus.Ep, bus.CE, bus.Ei, bus.Ea, bus.Eu}));

   a_tstate_onehot : assert property (@(posedge clk) disable iff (clr)
      $onehot(tstate));

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Scoreboard bench for sap1_control_sequencer: one full-cycle and one short-cycle instance.
// Expected vectors come from a behavioural reference model stepped on each falling edge.
module tb_sap1_control_sequencer;

   localparam logic [11:0] B_CP = 12'h800;
   localparam logic [11:0] B_EP = 12'h400;
   localparam logic [11:0] B_LM = 12'h200;
   localparam logic [11:0] B_CE = 12'h100;
   localparam logic [11:0] B_LI = 12'h080;
   localparam logic [11:0] B_EI = 12'h040;
   localparam logic [11:0] B_LA = 12'h020;
   localparam logic [11:0] B_EA = 12'h010;
   localparam logic [11:0] B_SU = 12'h008;
   localparam logic [11:0] B_EU = 12'h004;
   localparam logic [11:0] B_LB = 12'h002;
   localparam logic [11:0] B_LO = 12'h001;

   typedef struct {
      int          dut;
      logic [18:0] exp;
      string       tag;
   } sb_entry_t;

   logic       clk;
   logic       clr;
   logic [3:0] op;
   int         checks;
   int         failures;
   int         mt [2];
   bit         mh [2];
   sb_entry_t  sb [$];

   sap1_control_sequencer_if bus0 ();
   sap1_control_sequencer_if bus1 ();

   assign bus0.opCode = op;
   assign bus1.opCode = op;

   sap1_control_sequencer #(.SHORT_CYCLE(1'b0)) u_full (
      .clk (clk),
      .clr (clr),
      .bus (bus0)
   );

   sap1_control_sequencer #(.SHORT_CYCLE(1'b1)) u_short (
      .clk (clk),
      .clr (clr),
      .bus (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] ctrl_of(input int t, input logic [3:0] o);
      logic [11:0] w;
      w = '0;
      case (t)
         1: w = B_EP | B_LM;
         2: w = B_CP;
         3: w = B_CE | B_LI;
         4: begin
            if (o == 4'h0 || o == 4'h1 || o == 4'h2) w = B_EI | B_LM;
            else if (o == 4'hE)                      w = B_EA | B_LO;
         end
         5: begin
            if (o == 4'h0)                   w = B_CE | B_LA;
            else if (o == 4'h1 || o == 4'h2) w = B_CE | B_LB;
         end
         6: begin
            if (o == 4'h1)      w = B_EU | B_LA;
            else if (o == 4'h2) w = B_EU | B_LA | B_SU;
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic logic [18:0] model_vec(input int d);
      logic [5:0]  th;
      logic [11:0] c;
      th = 6'b000001 << (mt[d] - 1);
      c  = mh[d] ? 12'h000 : ctrl_of(mt[d], op);
      return {th, c, mh[d]};
   endfunction

   function automatic logic [18:0] actual(input int d);
      if (d == 0)
         return {bus0.tstate, bus0.Cp, bus0.Ep, bus0.Lm, bus0.CE, bus0.Li, bus0.Ei,
                 bus0.La, bus0.Ea, bus0.Su, bus0.Eu, bus0.Lb, bus0.Lo, bus0.hlt};
      return {bus1.tstate, bus1.Cp, bus1.Ep, bus1.Lm, bus1.CE, bus1.Li, bus1.Ei,
              bus1.La, bus1.Ea, bus1.Su, bus1.Eu, bus1.Lb, bus1.Lo, bus1.hlt};
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit sc;
         bit nop;
         sc  = (d == 1);
         nop = !(op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF});
         if (!mh[d]) begin
            case (mt[d])
               4: begin
                  if (op == 4'hF)               mh[d] = 1'b1;
                  else if (sc && (op == 4'hE || nop)) mt[d] = 1;
                  else                          mt[d] = 5;
               end
               5: mt[d] = (sc && op == 4'h0) ? 1 : 6;
               6: mt[d] = 1;
               default: mt[d] = mt[d] + 1;
            endcase
         end
      end
   endtask

   task automatic push_exp(input string tag, input bit clr_v);
      for (int d = 0; d < 2; d++) begin
         sb_entry_t e;
         e.dut = d;
         e.tag = tag;
         e.exp = clr_v ? {6'b000001, 12'h000, 1'b0} : model_vec(d);
         sb.push_back(e);
      end
   endtask

   task automatic compare_all();
      while (sb.size() > 0) begin
         sb_entry_t   e;
         logic [18:0] act;
         e   = sb.pop_front();
         act = actual(e.dut);
         checks++;
         if (act !== e.exp) begin
            failures++;
            $display("FAIL %s dut%0d: got tstate=%b ctrl=%b hlt=%b, want tstate=%b ctrl=%b hlt=%b",
                     e.tag, e.dut, act[18:13], act[12:1], act[0],
                     e.exp[18:13], e.exp[12:1], e.exp[0]);
         end
      end
   endtask

   task automatic cycle(input string tag);
      @(negedge clk);
      model_step();
      push_exp(tag, 1'b0);
      @(posedge clk);
      compare_all();
   endtask

   task automatic do_reset(input string tag);
      #2 clr = 1'b1;
      #1;
      mt[0] = 1; mt[1] = 1;
      mh[0] = 1'b0; mh[1] = 1'b0;
      push_exp({tag, "_clr_high"}, 1'b1);
      compare_all();
      @(posedge clk);
      #2 clr = 1'b0;
      #1;
      push_exp({tag, "_t1"}, 1'b0);
      compare_all();
   endtask

   task automatic test_reset();
      op = 4'hF;
      do_reset("reset");
      cycle("fetch_t2");
      cycle("fetch_t3");
   endtask

   task automatic run_op(input logic [3:0] o, input string tag);
      op = o;
      do_reset(tag);
      for (int i = 0; i < 8; i++) cycle(tag);
   endtask

   task automatic test_lda();  run_op(4'h0, "lda"); endtask
   task automatic test_add();  run_op(4'h1, "add"); endtask
   task automatic test_sub();  run_op(4'h2, "sub"); endtask
   task automatic test_out();  run_op(4'hE, "out"); endtask
   task automatic test_nop();  run_op(4'h7, "nop"); endtask

   task automatic test_fetch_ignores_opcode();
      op = 4'hF;
      do_reset("fetch_ign");
      op = 4'h7;
      cycle("fetch_ign_t2");
      op = 4'h2;
      cycle("fetch_ign_t3");
      op = 4'h1;
      for (int i = 0; i < 4; i++) cycle("fetch_ign_exec");
   endtask

   task automatic test_halt();
      op = 4'hF;
      do_reset("halt");
      for (int i = 0; i < 3; i++) cycle("halt_fetch");
      for (int i = 0; i < 10; i++) cycle("halt_hold");
      op = 4'h0;
      for (int i = 0; i < 3; i++) cycle("halt_op_ignored");
      do_reset("halt_exit");
      cycle("halt_exit_t2");
   endtask

   task automatic test_async_clr_mid();
      op = 4'h1;
      do_reset("midclr_start");
      for (int i = 0; i < 4; i++) cycle("midclr_to_t5");
      do_reset("midclr");
      for (int i = 0; i < 3; i++) cycle("midclr_after");
   endtask

   task automatic test_back_to_back();
      op = 4'h0;
      do_reset("random");
      for (int i = 0; i < 1200; i++) begin
         op = 4'($urandom_range(0, 14));
         cycle("random");
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clr      = 1'b0;
      op       = 4'hF;
      #1;
      test_reset();
      test_lda();
      test_add();
      test_sub();
      test_out();
      test_nop();
      test_fetch_ignores_opcode();
      test_halt();
      test_async_clr_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
